fetch_buffer: RTL
=================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of entries; SHALL be a power of two, >= 2.
REQ-002 Parameter CW, default $clog2(DEPTH)+1, width of count_o.
REQ-003 One clock, clk_i; reset is asynchronous and active-low, rst_ni.
REQ-004 clk_i  input  1  core clock; all state updates on rising edge.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 flush_i  input  1  redirect/flush; discards all entries.
REQ-007 push_valid_i  input  1  fetch stage presents an instruction.
REQ-008 push_pc_i  input  32  address of pushed instruction.
REQ-009 push_inst_i  input  32  pushed instruction word; 32'h0 denotes a bubble (NOP).
REQ-010 push_ready_o  output  1  buffer can accept a push this cycle.
REQ-011 stall_fetch_o  output  1  almost-full hint to PC/fetch.
REQ-012 pop_valid_o  output  1  head entry valid for decode.
REQ-013 pop_ready_i  input  1  decode consumes head entry.
REQ-014 pop_pc_o  output  32  head entry address.
REQ-015 pop_inst_o  output  32  head entry instruction.
REQ-016 count_o  output  CW  number of occupied entries, 0..DEPTH.

Function
REQ-017 Storage SHALL be DEPTH flop entries of {pc, inst}, with read/write pointers of $clog2(DEPTH) bits wrapping modulo DEPTH.
REQ-018 push_ready_o SHALL be 1 exactly when count_o < DEPTH; there is no push-when-full even with a simultaneous pop.
REQ-019 A push is accepted when push_valid_i && push_ready_o && push_inst_i != 32'h0 && !flush_i; the entry is written at wptr and wptr increments.
REQ-020 Pushes with push_inst_i == 32'h0 SHALL be dropped silently: no state change.
REQ-021 pop_valid_o SHALL equal (count_o != 0); there is no empty bypass, so push-to-pop_valid latency is exactly 1 cycle.
REQ-022 A pop occurs when pop_valid_o && pop_ready_i && !flush_i; rptr increments.
REQ-023 When empty, pop_pc_o and pop_inst_o SHALL read 32'h0; otherwise they show the entry at rptr, combinationally from storage.
REQ-024 count_o next value: +1 on push-only, -1 on pop-only, unchanged on simultaneous push and pop or neither.
REQ-025 flush_i SHALL have priority over push and pop in the same cycle; next cycle count_o=0, wptr=rptr=0, pop_valid_o=0.
REQ-026 stall_fetch_o SHALL be 1 when count_o >= DEPTH-1, combinational from count.
REQ-027 Storage contents need not be cleared on flush or reset; only pointers and count are cleared.

Reset
REQ-028 Asynchronous assertion of rst_ni SHALL immediately force wptr=0, rptr=0, count=0; outputs then read pop_valid_o=0, pop_pc_o=0, pop_inst_o=0, push_ready_o=1, stall_fetch_o=0, count_o=0.
REQ-029 A reset asserted mid-operation SHALL discard all entries exactly as a flush does; the first push is accepted on the first rising edge after rst_ni deasserts.

Structure
REQ-030 Shared core package SHALL hold NOP_INST = 32'h0000_0000 and typedef fetch_entry_t {logic [31:0] pc; logic [31:0] inst}.
REQ-031 Block SHALL be a single module with no sub-modules; pointer, count and storage logic are kept in separate always_ff processes.

Verification
REQ-032 Reset then push pc=0x0/inst=0x00000013 -> next cycle pop_valid_o=1, pop_pc_o=0x0, pop_inst_o=0x00000013, count_o=1.
REQ-033 Push 4 distinct instructions, pop_ready_i=0 -> count_o=4, push_ready_o=0, stall_fetch_o=1 from count 3; a 5th push is ignored; pops then return the entries in order.
REQ-034 Full buffer, push_valid_i=1 and pop_ready_i=1 in the same cycle -> only the pop occurs, count_o 4->3; simultaneous push+pop at count 2 -> count stays 2.
REQ-035 Push inst=32'h0 at pc=0x8 -> count_o unchanged and pop never shows pc 0x8.
REQ-036 count=3, flush_i=1 with push_valid_i=1 and pop_ready_i=1 -> next cycle count_o=0, pop_valid_o=0; a subsequent push at pc=0x100 pops first.
REQ-037 Run more than 2*DEPTH pushes/pops so the pointers wrap, with rst_ni pulsed asynchronously mid-stream -> order is preserved across the wrap and outputs are zero immediately on reset.

Source files
------------

// File: rtl/fetch_buffer_pkg.sv
// Shared core types for the fetch front end: the bubble encoding and the
// {pc, inst} entry carried between fetch and decode.
package fetch_buffer_pkg;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// Fetch-to-decode instruction queue. Bubbles are dropped on entry; a flush
// (redirect) empties it. There is no empty bypass: a push is visible one cycle later.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_valid_i,
  input  logic [31:0]   push_pc_i,
  input  logic [31:0]   push_inst_i,
  output logic          push_ready_o,
  output logic          stall_fetch_o,
  output logic          pop_valid_o,
  input  logic          pop_ready_i,
  output logic [31:0]   pop_pc_o,
  output logic [31:0]   pop_inst_o,
  output logic [CW-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] ALMOST_CNT = CW'(DEPTH - 1);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [CW-1:0]   cnt;
  logic            do_push, do_pop;
  fetch_entry_t    head;

  assign push_ready_o  = cnt < FULL_CNT;
  assign pop_valid_o   = cnt != '0;
  assign stall_fetch_o = cnt >= ALMOST_CNT;
  assign count_o       = cnt;

  assign do_push = push_valid_i && push_ready_o && (push_inst_i != NOP_INST) && !flush_i;
  assign do_pop  = pop_valid_o && pop_ready_i && !flush_i;

  // Empty reads as zero so decode never sees stale storage.
  assign head       = pop_valid_o ? mem[rptr] : '0;
  assign pop_pc_o   = head.pc;
  assign pop_inst_o = head.inst;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (flush_i) begin
      cnt <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is never cleared; pointers and count alone define occupancy.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= '{pc: push_pc_i, inst: push_inst_i};
  end
endmodule
